// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
// -----------------------------------------------------------------------------
// Coprocessor-0 exception controller for the 5-stage MIPS core. It merges the
// MEM-stage synchronous exception code with six level-sensitive hardware
// interrupt lines and raises a combinational flush/redirect request. It also
// holds SR, Cause, EPC and PRId and serves mfc0, mtc0 and eret.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   A1       mfc0 read register number
//   A2       mtc0 write register number
//   DIn      mtc0 write data
//   We       mtc0 write enable (MEM stage)
//   PC       word address [31:2] of the instruction in MEM
//   BD       instruction in MEM sits in a branch delay slot
//   ExcCode  exception code from the MEM exception check (0 = none)
//   HWInt    hardware interrupt lines [7:2], level-sensitive
//   EXLClr   eret in MEM
//   IntReq   take-exception request (flush, jump to the handler)
//   EPC      current EPC [31:2], used by eret
//   DOut     mfc0 read data
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2020_0615
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [29:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  // Cause fields
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  // EPC
  logic [29:0] epc_reg;

  logic        int_pend;
  logic        exc_pend;
  logic        sr_write;
  logic        epc_write;
  logic [29:0] victim_epc;

  // EXL masks both sources, so no nested entry can happen inside a handler.
  assign int_pend = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_pend = (ExcCode != 5'd0) & ~exl_reg;
  assign IntReq   = int_pend | exc_pend;

  // An mtc0 on the cycle of entry belongs to an instruction that never
  // commits, so it is qualified with !IntReq.
  assign sr_write  = We & ~IntReq & (A2 == REG_SR);
  assign epc_write = We & ~IntReq & (A2 == REG_EPC);

  // In a delay slot the handler must return to the branch, one word earlier.
  // The subtraction wraps naturally at 30 bits.
  assign victim_epc = BD ? (PC - 30'd1) : PC;

  always_ff @(posedge clk) begin
    if (reset) begin
      im_reg       <= 6'd0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= 6'd0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 30'd0;
    end else begin
      // Raw interrupt visibility, regardless of masking.
      ip_reg <= HWInt;

      if (IntReq) begin
        exl_reg      <= 1'b1;
        // An interrupt outranks a synchronous exception and is coded as 0.
        exc_code_reg <= int_pend ? 5'd0 : ExcCode;
        bd_reg       <= BD;
        epc_reg      <= victim_epc;
      end else begin
        if (sr_write) begin
          im_reg  <= DIn[15:10];
          ie_reg  <= DIn[0];
          exl_reg <= DIn[1];
        end
        if (epc_write) begin
          epc_reg <= DIn[31:2];
        end
        // eret takes precedence over an mtc0 to SR for the EXL bit only.
        if (EXLClr) begin
          exl_reg <= 1'b0;
        end
      end
    end
  end

  assign EPC = epc_reg;

  // Read mux shows registered state only.
  always_comb begin
    DOut = 32'h0;
    case (A1)
      REG_SR:    DOut = {16'h0, im_reg, 8'h0, exl_reg, ie_reg};
      REG_CAUSE: DOut = {bd_reg, 15'h0, ip_reg, 3'h0, exc_code_reg, 2'b00};
      REG_EPC:   DOut = {epc_reg, 2'b00};
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h2020_0615;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        We;
  logic [29:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state kept as whole architectural register words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [29:0] m_epc;

  cp0_exc_ctrl #(.PRID(PRID)) dut (
    .clk     (clk),
    .reset   (reset),
    .A1      (A1),
    .A2      (A2),
    .DIn     (DIn),
    .We      (We),
    .PC      (PC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .HWInt   (HWInt),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPC     (EPC),
    .DOut    (DOut)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic model_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic model_req();
    return model_int() || ((ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Applies the architectural rules for one clock edge using current inputs.
  task automatic model_edge();
    logic        take;
    logic        irq;
    logic [29:0] back;
    take = model_req();
    irq  = model_int();
    if (reset) begin
      m_sr    = 32'h0;
      m_cause = 32'h0;
      m_epc   = 30'h0;
    end else begin
      m_cause[15:10] = HWInt;
      if (take) begin
        m_sr[1]       = 1'b1;
        m_cause[6:2]  = irq ? 5'd0 : ExcCode;
        m_cause[31]   = BD;
        back          = PC - 30'd1;
        m_epc         = BD ? back : PC;
      end else begin
        if (We && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
        if (We && A2 == 5'd14) m_epc = DIn[31:2];
        if (EXLClr) m_sr[1] = 1'b0;
      end
    end
  endtask

  // One clock: check combinational outputs against the model, then advance.
  task automatic tick();
    @(negedge clk);
    check("intreq", {31'h0, IntReq}, {31'h0, model_req()});
    check("epc",    {2'b00, EPC},    {2'b00, m_epc});
    check("dout",   DOut,            model_read(A1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; We = 1'b0; ExcCode = 5'd0; EXLClr = 1'b0; BD = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string tag);
    A1 = a;
    #1;
    check(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; We = 1'b0; PC = 30'h0;
    BD = 1'b0; ExcCode = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset state, with an mtc0 that must be ignored.
    We = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    peek(5'd12, 32'h0, "rst_sr");
    peek(5'd13, 32'h0, "rst_cause");
    peek(5'd14, 32'h0, "rst_epc");
    peek(5'd15, PRID,  "rst_prid");
    check("rst_intreq", {31'h0, IntReq}, 32'h0);

    // Enabled interrupt entry.
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle();
    HWInt = 6'b000001; PC = 30'h100;
    #1 check("irq_req", {31'h0, IntReq}, 32'h1);
    tick();
    peek(5'd13, 32'h0000_0400, "irq_cause");
    peek(5'd12, 32'h0000_0403, "irq_sr");
    peek(5'd14, 32'h0000_0400, "irq_epc");
    check("irq_req_masked", {31'h0, IntReq}, 32'h0);
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    idle();
    We = 1'b1; A2 = 5'd12; DIn = 32'h0;
    tick();
    idle();

    // Delay-slot exception with interrupts disabled.
    ExcCode = 5'd4; PC = 30'h0C00; BD = 1'b1;
    #1 check("adel_req", {31'h0, IntReq}, 32'h1);
    tick();
    idle();
    peek(5'd13, 32'h8000_0010, "adel_cause");
    peek(5'd14, 32'h0000_2FFC, "adel_epc");
    EXLClr = 1'b1;
    tick();
    idle();

    // Interrupt outranks exception; mtc0 EPC in the entry cycle is dropped.
    We = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    idle();
    HWInt = 6'b000001; ExcCode = 5'd12; We = 1'b1; A2 = 5'd14;
    DIn = 32'hDEAD_BEE0; PC = 30'h55;
    tick();
    idle();
    peek(5'd13, 32'h0000_0400, "prio_cause");
    peek(5'd14, 32'h0000_0154, "prio_epc");

    // Nested request suppressed while EXL=1, then eret re-exposes the irq.
    ExcCode = 5'd5;
    #1 check("nest_req", {31'h0, IntReq}, 32'h0);
    tick();
    peek(5'd13, 32'h0000_0400, "nest_cause");
    peek(5'd14, 32'h0000_0154, "nest_epc");
    ExcCode = 5'd0; EXLClr = 1'b1;
    tick();
    idle();
    #1 check("eret_req", {31'h0, IntReq}, 32'h1);
    tick();

    // Reset in the middle of a handler overrides a concurrent mtc0.
    We = 1'b1; A2 = 5'd14; DIn = {30'h1234, 2'b00};
    tick();
    idle();
    peek(5'd14, 32'h0000_48D0, "mid_epc");
    reset = 1'b1; We = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    HWInt = 6'd0;
    peek(5'd12, 32'h0, "mid_rst_sr");
    peek(5'd13, 32'h0, "mid_rst_cause");
    peek(5'd14, 32'h0, "mid_rst_epc");
    check("mid_rst_req", {31'h0, IntReq}, 32'h0);

    // EPC wrap for PC=0 in a delay slot.
    ExcCode = 5'd1; PC = 30'h0; BD = 1'b1;
    tick();
    idle();
    peek(5'd14, 32'hFFFF_FFFC, "wrap_epc");
    EXLClr = 1'b1;
    tick();
    idle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      A2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      DIn     = $urandom;
      We      = ($urandom_range(0, 2) == 0);
      PC      = ($urandom_range(0, 7) == 0) ? 30'h0 : 30'($urandom);
      BD      = $urandom_range(0, 1) == 1;
      ExcCode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      HWInt   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      EXLClr  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
